// File: rtl/reg_writeback_pkg.sv
// Shared types for the integer register-file write-back path.
//
// Contents:
//   REG_COUNT / REG_ADDR_W  architectural register count and index width
//   regName_t               register index type
//   wb_src_t                which producer owns the write slot this cycle
//   rr_side_t               round-robin side (load or mul/div)
//   reg_mask()              one-hot register mask, x0 always maps to zero
package reg_writeback_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] regName_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LD   = 2'd2,
    WB_MD   = 2'd3
  } wb_src_t;

  typedef enum logic {
    GRANT_LD = 1'b0,
    GRANT_MD = 1'b1
  } rr_side_t;

  // x0 is hardwired zero, so it never owns a scoreboard bit.
  function automatic logic [REG_COUNT-1:0] reg_mask(input regName_t r);
    logic [REG_COUNT-1:0] m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_writeback_arb.sv
// Two-requester round-robin arbiter for the load and mul/div producers.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   enable     slot is free for ld/md (no ALU result, not in reset)
//   req_ld     load result offered
//   req_md     mul/div result offered
//   gnt_ld     load granted (combinational)
//   gnt_md     mul/div granted (combinational)
//
// A grant is only issued to a requester that is valid, so every grant is a
// transfer; last_grant therefore moves only on real transfers.
module wb_rr_arb
  import reg_writeback_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic req_ld,
  input  logic req_md,
  output logic gnt_ld,
  output logic gnt_md
);

  rr_side_t last_grant;
  rr_side_t last_grant_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_MD;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    gnt_ld          = 1'b0;
    gnt_md          = 1'b0;
    last_grant_next = last_grant;

    if (enable) begin
      if (req_ld && req_md) begin
        // Tie: the side that did not win last time goes now.
        if (last_grant == GRANT_MD) gnt_ld = 1'b1;
        else                        gnt_md = 1'b1;
      end else if (req_ld) begin
        gnt_ld = 1'b1;
      end else if (req_md) begin
        gnt_md = 1'b1;
      end
    end

    if (gnt_ld)      last_grant_next = GRANT_LD;
    else if (gnt_md) last_grant_next = GRANT_MD;
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-side controller for the integer register file.
//
// Picks at most one result per cycle from ALU, load and mul/div, registers it
// onto the register-file write port, and keeps a per-register pending-write
// scoreboard for decode.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data   ALU result, always accepted
//   ld_valid/ld_ready/ld_rd/ld_data   load result handshake
//   md_valid/md_ready/md_rd/md_data   mul/div result handshake
//   issue_valid/issue_rd        decode issued an instruction writing issue_rd
//   busy                        bit i set while a write to register i is outstanding
//   wen/rd/data_in              registered register-file write port
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  alu_valid,
  input  regName_t              alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,

  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  regName_t              ld_rd,
  input  logic [DATA_WIDTH-1:0] ld_data,

  input  logic                  md_valid,
  output logic                  md_ready,
  input  regName_t              md_rd,
  input  logic [DATA_WIDTH-1:0] md_data,

  input  logic                  issue_valid,
  input  regName_t              issue_rd,
  output logic [REG_COUNT-1:0]  busy,

  output logic                  wen,
  output regName_t              rd,
  output logic [DATA_WIDTH-1:0] data_in
);

  logic                  gnt_ld;
  logic                  gnt_md;
  wb_src_t               src;
  regName_t              sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  commit;
  logic                  do_write;
  logic [REG_COUNT-1:0]  busy_next;

  // ALU takes the slot outright; holding rst out of enable drops both
  // ready lines combinationally during reset.
  wb_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (!rst && !alu_valid),
    .req_ld (ld_valid),
    .req_md (md_valid),
    .gnt_ld (gnt_ld),
    .gnt_md (gnt_md)
  );

  assign ld_ready = gnt_ld;
  assign md_ready = gnt_md;

  always_comb begin
    src = WB_NONE;
    if (alu_valid)   src = WB_ALU;
    else if (gnt_ld) src = WB_LD;
    else if (gnt_md) src = WB_MD;
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    unique case (src)
      WB_ALU: begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
      WB_LD: begin
        sel_rd   = ld_rd;
        sel_data = ld_data;
      end
      WB_MD: begin
        sel_rd   = md_rd;
        sel_data = md_data;
      end
      default: begin
        sel_rd   = '0;
        sel_data = '0;
      end
    endcase
  end

  assign commit   = (src != WB_NONE);
  // Results aimed at x0 are consumed but never reach the register file.
  assign do_write = commit && (sel_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen     <= 1'b0;
      rd      <= '0;
      data_in <= '0;
    end else begin
      wen <= do_write;
      if (do_write) begin
        rd      <= sel_rd;
        data_in <= sel_data;
      end
    end
  end

  // Clear first, then set: a fresh issue to the register being written
  // back must stay pending, since that new producer is still outstanding.
  always_comb begin
    busy_next = busy;
    if (commit)      busy_next = busy_next & ~reg_mask(sel_rd);
    if (issue_valid) busy_next = busy_next | reg_mask(issue_rd);
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side controller for the 32-entry integer register file. It collects results from three producers and commits at most one register write per cycle, driving the register file's write enable, destination and data lines. The producers are the single-cycle ALU, the load unit and the multi-cycle mul/div unit. It also keeps a per-register pending scoreboard so decode can stall on registers with an outstanding write. It sits between the execute/memory stages and `reg_file`.

## Interface

- `DATA_WIDTH`, 32, result/data width
- `REG_COUNT`, 32, number of architectural registers (from `definitions`)

- `clk`  in  1  clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle; always accepted
- `alu_rd`  in  regName_t  ALU destination
- `alu_data`  in  DATA_WIDTH  ALU result
- `ld_valid`  in  1  load result offered
- `ld_ready`  out  1  load result accepted this cycle
- `ld_rd`  in  regName_t  load destination
- `ld_data`  in  DATA_WIDTH  load result
- `md_valid`  in  1  mul/div result offered
- `md_ready`  out  1  mul/div result accepted this cycle
- `md_rd`  in  regName_t  mul/div destination
- `md_data`  in  DATA_WIDTH  mul/div result
- `issue_valid`  in  1  decode issued an instruction with a destination
- `issue_rd`  in  regName_t  destination of issued instruction
- `busy`  out  REG_COUNT  scoreboard; bit i = write to register i outstanding
- `wen`  out  1  register-file write enable (registered)
- `rd`  out  regName_t  register-file write address (registered)
- `data_in`  out  DATA_WIDTH  register-file write data (registered)

## Operation

- Source priority each cycle: ALU > {load, mul/div}. Load and mul/div share the remaining slot round-robin.
- Handshake: a transfer on ld/md occurs when `valid && ready`. `ready` is combinational and asserted only for the granted source. `valid`, `rd` and `data` hold stable until accepted.
- If `alu_valid` = 1, both `ld_ready` and `md_ready` = 0.
- Round-robin: a 1-bit `last_grant` selects between load and mul/div.
  - When both are valid, the one not granted last wins.
  - When only one is valid, it wins.
  - `last_grant` updates only on an actual ld/md transfer. Reset value is md, so load wins the first tie.
- Accepted result registers into `wen`/`rd`/`data_in` at the next rising edge.
- Destination x0: the transfer is accepted (ready asserted as usual), but `wen` stays 0 and `rd`/`data_in` hold their previous values.
- Scoreboard bit set: on `issue_valid` with `issue_rd` ≠ 0, set `busy[issue_rd]` at the next edge.
- Scoreboard bit clear: on an accepted transfer with destination ≠ 0, clear `busy[dest]` at the next edge.
- Same register set and cleared in one cycle: set wins, because the new producer is outstanding.
- `busy[0]` is constant 0.
- No state machine beyond `last_grant` and the scoreboard. The write stage is a single pipeline register.

## Timing

- Reset (asynchronous, immediate):
  - `wen` = 0, `rd` = 0, `data_in` = 0
  - `busy` = 0
  - `last_grant` = md
  - `ld_ready` and `md_ready` drop combinationally to 0 while `rst` = 1
- Latency: producer accept at edge N → `wen`/`rd`/`data_in` valid from edge N+1 for one cycle.
  - The register file writes at that cycle's falling edge, so the value is readable combinationally in the second half of cycle N+1.
- `busy` clears at edge N+1, the same edge at which `wen` rises.
- Throughput: one write per cycle. Under continuous `alu_valid`, ld/md starve by design.
- Reset asserted mid-transfer: a pending `wen` is dropped. Producers must re-offer after reset.

## Structure

- Add to `definitions` package:
  - `wb_src_t` enum {`WB_NONE`, `WB_ALU`, `WB_LD`, `WB_MD`}
  - reuse the existing `regName_t` and `REG_COUNT`
- One sub-module: `wb_rr_arb`, a 2-requester round-robin arbiter with `last_grant` state. The ALU override and the scoreboard stay in `reg_writeback`.

## Test plan

- Reset: assert `rst` mid-cycle with `wen` = 1 → `wen`, `rd`, `data_in` and `busy` go to 0 immediately. After release, `reg_file` read of x5 returns 0.
- ALU write: `alu_valid` = 1, `alu_rd` = 5, `alu_data` = 0xDEADBEEF → next cycle `wen` = 1, `rd` = 5, `data_in` = 0xDEADBEEF. `reg_file` read of x5 returns 0xDEADBEEF after the falling edge.
- Contention: ALU (rd 3), load (rd 4) and mul/div (rd 6) all valid in one cycle, ALU deasserted next cycle.
  - Cycle 1: ALU wins; `ld_ready` = `md_ready` = 0.
  - Cycle 2: load wins.
  - Cycle 3: mul/div wins.
  - Commit order on `rd`: 3, 4, 6 on consecutive cycles.
- Round-robin fairness: load and mul/div held valid for 6 cycles, no ALU → grants alternate ld, md, ld, md, ld, md.
- Scoreboard:
  - `issue_rd` = 7 → `busy[7]` = 1.
  - Later, load commits rd 7 in the same cycle as `issue_rd` = 7 → `busy[7]` stays 1.
  - Next commit of rd 7 with no issue → `busy[7]` = 0.
- x0 destination: `ld_rd` = 0, `ld_data` = 0x1234 → `ld_ready` = 1, `wen` stays 0, `busy` unchanged, and x0 still reads 0.
